alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares a single integer ALU instance between two requesters, the integer execute pipe (port 0) and the branch/address-generation unit (port 1), using valid/ready handshakes. Each port has a one-entry response buffer, so a stalled consumer blocks only its own port. Arbitration is round-robin by default. The block sits between the issue logic and the ALU, and owns the only ALU instance in the core.

## Interface
- XLEN, 32, operand/result width (the ALU is fixed at 32; other values are illegal)
- TAG_W, 4, width of the opaque tag carried from request to response
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- rN_valid  in  1  request valid, port N ∈ {0,1}
- rN_ready  out  1  request accepted this cycle when rN_valid & rN_ready
- rN_a  in  XLEN  operand A
- rN_b  in  XLEN  operand B
- rN_ctr  in  4  ALU control code, passed to the ALU unchanged
- rN_tag  in  TAG_W  opaque tag
- rN_rsp_valid  out  1  response valid
- rN_rsp_ready  in  1  consumer accepts the response
- rN_rsp_result  out  XLEN  ALU result
- rN_rsp_zero  out  1  adder zero flag for that operation
- rN_rsp_tag  out  TAG_W  tag echoed from the request

## Operation
- Eligibility: port N is eligible when rN_valid is high and its response slot is empty, or the slot is full and rN_rsp_ready is high (drain and refill in the same cycle).
- Grant: at most one port per cycle. rN_ready is high only for the granted port. rN_ready may depend combinationally on rN_valid and rN_rsp_ready.
- Datapath: the granted port's a, b and ctr drive the ALU combinationally.
- Capture: on the accepting edge, the ALU result, zero flag and tag are written into the granted port's slot, and rN_rsp_valid is set.
- Slot update on each edge:
  - rsp_valid & rsp_ready with no new accept: the slot empties.
  - Drain and accept in the same cycle: the new response replaces the old one and rsp_valid stays high.
- Round-robin:
  - A 1-bit last_grant register records the most recent accepted port.
  - When both ports are eligible, grant the port ≠ last_grant.
  - When one port is eligible, grant it.
  - last_grant updates only on an accepted transfer.
- Responses are returned in per-port request order. Nothing is reordered across ports.
- Grant never depends on the other port's response state. A blocked port 0 must not stall port 1.

## Timing
- Request-to-response latency: 1 cycle. A request accepted in cycle N produces rsp_valid in cycle N+1.
- Aggregate throughput: 1 op/cycle. Per-port throughput: 1 op/cycle while that port's rsp_ready stays high.
- Reset values:
  - rN_ready = 0 while rst is high.
  - rN_rsp_valid = 0, rN_rsp_result = 0, rN_rsp_zero = 0, rN_rsp_tag = 0.
  - last_grant = 1, so port 0 wins the first contention.
- Reset mid-operation: buffered responses are discarded and no response is produced for a request accepted in the reset cycle.
- Response outputs stay stable while rsp_valid is high and rsp_ready is low.

## Configuration
- ALU_ARB_RR_EN defined: round-robin arbitration as described above.
- ALU_ARB_RR_EN undefined:
  - Fixed priority: port 0 always wins when both ports are eligible.
  - last_grant is not implemented.
  - All other behaviour is identical.

## Structure
- Shared package alu_pkg holds:
  - the ALU control encodings: ADD=4'b0000, SUB=4'b1000, SLT=4'b0010, SLTU=4'b1010, PASSB=4'b0011, XOR=4'b0100, OR=4'b0110, AND=4'b0111;
  - the XLEN constant;
  - a response struct {result, zero, tag}.
- One sub-module: alu, the existing integer ALU, instantiated once inside alu_arbiter.
- The arbiter and the response slots are written inline.

## Test plan
- Single op on port 0: a=5, b=7, ctr=ADD, tag=3 → r0_rsp_valid one cycle later with result=12, zero=0, tag=3.
- Zero flag on port 1: a=3, b=3, ctr=SUB → r1_rsp_result=0, r1_rsp_zero=1.
- Contention: both ports valid every cycle with rsp_ready=1, port 0 ops ADD 1+1 and port 1 ops XOR 0xF0^0x0F → grants alternate 0,1,0,1 starting with port 0. With the macro undefined, port 0 wins every cycle.
- Backpressure: r0_rsp_ready=0 with the port 0 slot full and both ports valid → r0_ready=0, r1 is granted every cycle, the port 0 response is held stable, and raising r0_rsp_ready drains and refills in the same cycle.
- Compare ops: a=1, b=0xFFFFFFFF with ctr=SLTU → result 1; with ctr=SLT → result 0.
- Reset: assert rst for one cycle while both slots are full and a request is being accepted → all rsp_valid=0 the next cycle, no stale response appears, and the first contention after reset goes to port 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, control encodings and the
// response record stored in each arbiter port's response slot.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;

    // Control codes are passed from the requester straight to the ALU.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b1000,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b1010,
        ALU_PASSB = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_OR    = 4'b0110,
        ALU_AND   = 4'b0111
    } alu_ctr_e;

    typedef struct packed {
        logic [XLEN-1:0]  result;
        logic             zero;
        logic [TAG_W-1:0] tag;
    } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// One requester port of the ALU arbiter: request handshake plus the
// response handshake coming back from that port's response slot.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic             valid;
    logic             ready;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [3:0]       ctr;
    logic [TAG_W-1:0] tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  rsp_result;
    logic             rsp_zero;
    logic [TAG_W-1:0] rsp_tag;

    // Requester side (issue logic / consumer).
    modport master (
        output valid, a, b, ctr, tag, rsp_ready,
        input  ready, rsp_valid, rsp_result, rsp_zero, rsp_tag
    );

    // Arbiter side.
    modport slave (
        input  valid, a, b, ctr, tag, rsp_ready,
        output ready, rsp_valid, rsp_result, rsp_zero, rsp_tag
    );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit integer ALU. The zero flag reflects the adder
// output: a+b for ADD, a-b for every other code.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      ctr_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    alu_ctr_e        ctr;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] adder;

    assign ctr   = alu_ctr_e'(ctr_i);
    assign sum   = a_i + b_i;
    assign diff  = a_i - b_i;
    assign adder = (ctr == ALU_ADD) ? sum : diff;

    // Operation select; undefined codes yield zero.
    always_comb begin
        result_o = '0;
        zero_o   = (adder == '0);
        case (ctr)
            ALU_ADD:   result_o = sum;
            ALU_SUB:   result_o = diff;
            ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_PASSB: result_o = b_i;
            ALU_XOR:   result_o = a_i ^ b_i;
            ALU_OR:    result_o = a_i | b_i;
            ALU_AND:   result_o = a_i & b_i;
            default:   result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the single integer ALU. Each port owns a
// one-entry response slot, so a stalled consumer only blocks its own port.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without
// it, port 0 has fixed priority and no last-grant state exists.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave r0,
    alu_arbiter_if.slave r1
);

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [1:0]       slot_valid_q;
    alu_rsp_t         slot_q [2];

    logic [XLEN-1:0]  req_a   [2];
    logic [XLEN-1:0]  req_b   [2];
    logic [3:0]       req_ctr [2];
    logic [TAG_W-1:0] req_tag [2];

    logic [XLEN-1:0]  alu_a;
    logic [XLEN-1:0]  alu_b;
    logic [3:0]       alu_ctr;
    logic [XLEN-1:0]  alu_result;
    logic             alu_zero;

    // Flatten the two interface ports into indexable arrays.
    assign req_valid  = {r1.valid, r0.valid};
    assign rsp_ready  = {r1.rsp_ready, r0.rsp_ready};
    assign req_a[0]   = r0.a;
    assign req_a[1]   = r1.a;
    assign req_b[0]   = r0.b;
    assign req_b[1]   = r1.b;
    assign req_ctr[0] = r0.ctr;
    assign req_ctr[1] = r1.ctr;
    assign req_tag[0] = r0.tag;
    assign req_tag[1] = r1.tag;

    // A port may be granted when its slot is empty or is draining this cycle;
    // the decision never looks at the other port's slot.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = req_valid[gi] & (~slot_valid_q[gi] | rsp_ready[gi]);
        end
    endgenerate

`ifdef ALU_ARB_RR_EN
    logic last_grant_q;

    // Remember the most recently accepted port; port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (grant != 2'b00) begin
            last_grant_q <= grant[1];
        end
    end
`endif

    // Pick at most one eligible port; nothing is accepted during reset.
    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            grant = last_grant_q ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end
        if (rst) begin
            grant = 2'b00;
        end
    end

    // The granted port's operands drive the shared ALU.
    assign alu_a   = grant[1] ? req_a[1]   : req_a[0];
    assign alu_b   = grant[1] ? req_b[1]   : req_b[0];
    assign alu_ctr = grant[1] ? req_ctr[1] : req_ctr[0];

    alu u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .ctr_i    (alu_ctr),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Response slots: accept overwrites (also when draining), drain empties,
    // otherwise hold so outputs stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_q <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    slot_valid_q[i]  <= 1'b1;
                    slot_q[i].result <= alu_result;
                    slot_q[i].zero   <= alu_zero;
                    slot_q[i].tag    <= req_tag[i];
                end else if (rsp_ready[i]) begin
                    slot_valid_q[i]  <= 1'b0;
                end
            end
        end
    end

    assign r0.ready      = grant[0];
    assign r1.ready      = grant[1];
    assign r0.rsp_valid  = slot_valid_q[0];
    assign r1.rsp_valid  = slot_valid_q[1];
    assign r0.rsp_result = slot_q[0].result;
    assign r1.rsp_result = slot_q[1].result;
    assign r0.rsp_zero   = slot_q[0].zero;
    assign r1.rsp_zero   = slot_q[1].zero;
    assign r0.rsp_tag    = slot_q[0].tag;
    assign r1.rsp_tag    = slot_q[1].tag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter; expectations follow the build option
// ALU_ARB_RR_EN (round-robin) or its absence (fixed priority).
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0] exp_g;

    alu_arbiter_if r0_if ();
    alu_arbiter_if r1_if ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .r0  (r0_if),
        .r1  (r1_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctr, input logic [3:0] tag);
        r0_if.valid = v;
        r0_if.a     = a;
        r0_if.b     = b;
        r0_if.ctr   = ctr;
        r0_if.tag   = tag;
    endtask

    task automatic req1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] ctr, input logic [3:0] tag);
        r1_if.valid = v;
        r1_if.a     = a;
        r1_if.b     = b;
        r1_if.ctr   = ctr;
        r1_if.tag   = tag;
    endtask

    initial begin
        rst = 1'b1;
        r0_if.rsp_ready = 1'b1;
        r1_if.rsp_ready = 1'b1;
        req0(1'b1, 32'd5, 32'd7, ALU_ADD, 4'd3);
        req1(1'b1, 32'd3, 32'd3, ALU_SUB, 4'd5);
        tick();
        tick();

        // Reset state: valid requests are not accepted while rst is high
        check("rst_ready", 32'({r1_if.ready, r0_if.ready}), 32'd0);
        check("rst_rspv", 32'({r1_if.rsp_valid, r0_if.rsp_valid}), 32'd0);
        check("rst_r0_result", r0_if.rsp_result, 32'd0);
        check("rst_r1_zero", 32'(r1_if.rsp_zero), 32'd0);
        check("rst_r0_tag", 32'(r0_if.rsp_tag), 32'd0);
        req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        rst = 1'b0;
        tick();

        // Single ADD on port 0
        req0(1'b1, 32'd5, 32'd7, ALU_ADD, 4'd3);
        #1 check("add_ready", 32'({r1_if.ready, r0_if.ready}), 32'd1);
        tick();
        req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        check("add_rspv", 32'(r0_if.rsp_valid), 32'd1);
        check("add_result", r0_if.rsp_result, 32'd12);
        check("add_zero", 32'(r0_if.rsp_zero), 32'd0);
        check("add_tag", 32'(r0_if.rsp_tag), 32'd3);
        tick();
        check("add_drained", 32'(r0_if.rsp_valid), 32'd0);

        // Compare ops back to back on port 0
        req0(1'b1, 32'd1, 32'hFFFF_FFFF, ALU_SLTU, 4'd4);
        tick();
        check("sltu_result", r0_if.rsp_result, 32'd1);
        req0(1'b1, 32'd1, 32'hFFFF_FFFF, ALU_SLT, 4'd5);
        tick();
        check("slt_result", r0_if.rsp_result, 32'd0);
        check("slt_tag", 32'(r0_if.rsp_tag), 32'd5);
        req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        tick();

        // Zero flag on port 1
        req1(1'b1, 32'd3, 32'd3, ALU_SUB, 4'd5);
        tick();
        req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        check("sub_result", r1_if.rsp_result, 32'd0);
        check("sub_zero", 32'(r1_if.rsp_zero), 32'd1);
        check("sub_tag", 32'(r1_if.rsp_tag), 32'd5);
        tick();
        check("sub_drained", 32'(r1_if.rsp_valid), 32'd0);

        // Contention with both consumers ready
        req0(1'b1, 32'd1, 32'd1, ALU_ADD, 4'd1);
        req1(1'b1, 32'hF0, 32'h0F, ALU_XOR, 4'd2);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_g = 2'b01;
`endif
            #1 check("cont_grant", 32'({r1_if.ready, r0_if.ready}), 32'(exp_g));
            tick();
            check("cont_rspv", 32'({r1_if.rsp_valid, r0_if.rsp_valid}), 32'(exp_g));
            check("cont_result", exp_g[0] ? r0_if.rsp_result : r1_if.rsp_result,
                  exp_g[0] ? 32'd2 : 32'hFF);
        end
        req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        tick();

        // Backpressure on port 0
        r0_if.rsp_ready = 1'b0;
        req0(1'b1, 32'd10, 32'd20, ALU_ADD, 4'd7);
        tick();
        check("bp_fill_result", r0_if.rsp_result, 32'd30);
        req0(1'b1, 32'd1, 32'd1, ALU_ADD, 4'd1);
        req1(1'b1, 32'hF0, 32'h0F, ALU_XOR, 4'd2);
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_grant", 32'({r1_if.ready, r0_if.ready}), 32'd2);
            tick();
            check("bp_r0_hold_v", 32'(r0_if.rsp_valid), 32'd1);
            check("bp_r0_hold_res", r0_if.rsp_result, 32'd30);
            check("bp_r0_hold_tag", 32'(r0_if.rsp_tag), 32'd7);
            check("bp_r1_result", r1_if.rsp_result, 32'hFF);
        end
        r0_if.rsp_ready = 1'b1;
        #1 check("bp_refill_grant", 32'({r1_if.ready, r0_if.ready}), 32'd1);
        tick();
        check("bp_refill_v", 32'(r0_if.rsp_valid), 32'd1);
        check("bp_refill_res", r0_if.rsp_result, 32'd2);
        check("bp_refill_tag", 32'(r0_if.rsp_tag), 32'd1);

        // Reset while both slots are full and port 1 is being offered a request
        r0_if.rsp_ready = 1'b0;
        #1 check("pre_rst_grant", 32'({r1_if.ready, r0_if.ready}), 32'd2);
        tick();
        check("pre_rst_full", 32'({r1_if.rsp_valid, r0_if.rsp_valid}), 32'd3);
        rst = 1'b1;
        #1 check("mid_rst_ready", 32'({r1_if.ready, r0_if.ready}), 32'd0);
        tick();
        rst = 1'b0;
        r0_if.rsp_ready = 1'b1;
        check("post_rst_rspv", 32'({r1_if.rsp_valid, r0_if.rsp_valid}), 32'd0);
        check("post_rst_result", r0_if.rsp_result, 32'd0);
        check("post_rst_tag", 32'(r1_if.rsp_tag), 32'd0);
        #1 check("post_rst_grant", 32'({r1_if.ready, r0_if.ready}), 32'd1);
        tick();
        check("post_rst_r0v", 32'(r0_if.rsp_valid), 32'd1);
        check("post_rst_r0res", r0_if.rsp_result, 32'd2);
        check("post_rst_r1v", 32'(r1_if.rsp_valid), 32'd0);
        req0(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        req1(1'b0, 32'd0, 32'd0, ALU_ADD, 4'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
